// File: rtl/sprite_mem_pkg.sv
`default_nettype none
// ============================================================================
// sprite_mem_pkg
// Shared state encoding and default geometry for the sprite memory arbiter.
// Rev 1.0
// ============================================================================
package sprite_mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_t;

    localparam int SPRITE_ADDR_W = 14;
    localparam int SPRITE_DATA_W = 9;
    localparam int SPRITE_DEPTH  = 16384;

endpackage
`default_nettype wire

// File: rtl/sprite_memory_arbiter_valid_delay_line.sv
`default_nettype none
// ============================================================================
// valid_delay_line
// Shift register tracking which memory cycles carry an outstanding read.
// Rev 1.0
// ============================================================================
module valid_delay_line #(
    parameter int STAGES = 3
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_push,
    output logic o_pop
);

    logic [STAGES-1:0] r_shift;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) r_shift <= '0;
                else         r_shift <= i_push;
            end
        end else begin : g_multi
            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) r_shift <= '0;
                else         r_shift <= {r_shift[STAGES-2:0], i_push};
            end
        end
    endgenerate

    assign o_pop = r_shift[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sprite_memory_arbiter.sv
`default_nettype none
// ============================================================================
// sprite_memory_arbiter
// Clears sprite memory after reset, then shares its port: reads first, writes
// force-granted after a bounded wait.  Rev 1.0
// ============================================================================
module sprite_memory_arbiter
    import sprite_mem_pkg::*;
#(
    parameter int                ADDR_W       = SPRITE_ADDR_W,
    parameter int                DATA_W       = SPRITE_DATA_W,
    parameter int                DEPTH        = SPRITE_DEPTH,
    parameter int                READ_LATENCY = 2,
    parameter int                STARVE_LIMIT = 8,
    parameter bit                CLEAR_EN     = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rd_valid,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ready,
    output logic              o_rd_data_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic              o_init_done,
    output logic              o_starve_force
);

    localparam int                c_cnt_w        = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_starve_limit = c_cnt_w'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] c_last_addr    = ADDR_W'(DEPTH - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [c_cnt_w-1:0]  r_starve_cnt;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_data;
    logic                r_mem_wren;
    logic                r_init_done;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_data_valid;
    logic                w_run;
    logic                w_force;
    logic                w_rd_ready;
    logic                w_wr_ready;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_starve_force;
    logic                w_rd_return;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= CLEAR_EN ? ST_CLEAR : ST_RUN;
        else         r_state <= w_state_nxt;
    end

    // Gating on init_done keeps both readies low in reset and during the
    // first cycle after release when the sweep is disabled.
    always_comb begin
        w_state_nxt    = r_state;
        w_run          = (r_state == ST_RUN) && r_init_done;
        w_force        = (r_starve_cnt == c_starve_limit);
        w_rd_ready     = w_run && !w_force;
        w_wr_ready     = w_run && (w_force || !i_rd_valid);
        w_rd_acc       = i_rd_valid && w_rd_ready;
        w_wr_acc       = i_wr_valid && w_wr_ready && !w_rd_acc;
        w_starve_force = w_run && w_force && i_wr_valid;
        case (r_state)
            ST_CLEAR: if (r_clr_addr == c_last_addr) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_clr_addr      <= '0;
            r_starve_cnt    <= '0;
            r_mem_address   <= '0;
            r_mem_data      <= '0;
            r_mem_wren      <= 1'b0;
            r_init_done     <= 1'b0;
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_mem_address <= r_clr_addr;
                    r_mem_data    <= CLEAR_VALUE;
                    r_mem_wren    <= 1'b1;
                    r_clr_addr    <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_last_addr) r_init_done <= 1'b1;
                end
                default: begin
                    r_init_done <= 1'b1;
                    if (w_rd_acc) begin
                        r_mem_address <= i_rd_addr;
                        r_mem_wren    <= 1'b0;
                    end else if (w_wr_acc) begin
                        r_mem_address <= i_wr_addr;
                        r_mem_data    <= i_wr_data;
                        r_mem_wren    <= 1'b1;
                    end else begin
                        r_mem_wren    <= 1'b0;
                    end
                end
            endcase

            if (!i_wr_valid || w_wr_acc)          r_starve_cnt <= '0;
            else if (r_starve_cnt != c_starve_limit) r_starve_cnt <= r_starve_cnt + 1'b1;

            if (w_rd_return) begin
                r_rd_data       <= i_mem_q;
                r_rd_data_valid <= 1'b1;
            end else begin
                r_rd_data_valid <= 1'b0;
            end
        end
    end

    // One extra stage beyond the memory latency for the rd_data register.
    valid_delay_line #(
        .STAGES (READ_LATENCY + 1)
    ) u_valid_delay_line (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_rd_acc),
        .o_pop   (w_rd_return)
    );

    assign o_rd_ready      = w_rd_ready;
    assign o_wr_ready      = w_wr_ready;
    assign o_starve_force  = w_starve_force;
    assign o_mem_address   = r_mem_address;
    assign o_mem_data      = r_mem_data;
    assign o_mem_wren      = r_mem_wren;
    assign o_init_done     = r_init_done;
    assign o_rd_data       = r_rd_data;
    assign o_rd_data_valid = r_rd_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_sprite_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sprite_memory_arbiter
// Directed plus random stimulus against a transaction-level arbiter model.
// Rev 1.0
// ============================================================================
module tb_sprite_memory_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 9;
    localparam int DEP   = 16;
    localparam int LAT   = 2;
    localparam int LIMIT = 8;
    localparam logic [DW-1:0] CLR = 9'h1FF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ready;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic          init_done;
    logic          starve_force;

    sprite_memory_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .READ_LATENCY(LAT),
        .STARVE_LIMIT(LIMIT), .CLEAR_EN(1'b1), .CLEAR_VALUE(CLR)
    ) dut (
        .i_clock(clk), .i_reset(rst),
        .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
        .o_rd_data_valid(rd_data_valid), .o_rd_data(rd_data),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready),
        .o_mem_address(mem_address), .o_mem_data(mem_data), .o_mem_wren(mem_wren),
        .i_mem_q(mem_q), .o_init_done(init_done), .o_starve_force(starve_force)
    );

    always #5 clk = ~clk;

    // Memory stand-in: returns the address as data, two edges after it is presented.
    logic [DW-1:0] q_s0 = '0;
    logic [DW-1:0] q_s1 = '0;
    always @(posedge clk) begin
        q_s0 <= DW'(mem_address);
        q_s1 <= q_s0;
    end
    assign mem_q = q_s1;

    typedef struct { int due; logic [DW-1:0] d; } rd_exp_t;
    rd_exp_t       exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            wait_cycles = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".mem_address"},   32'(mem_address),   32'd0);
        chk({tag, ".mem_data"},      32'(mem_data),      32'd0);
        chk({tag, ".mem_wren"},      32'(mem_wren),      32'd0);
        chk({tag, ".rd_data"},       32'(rd_data),       32'd0);
        chk({tag, ".rd_data_valid"}, 32'(rd_data_valid), 32'd0);
        chk({tag, ".init_done"},     32'(init_done),     32'd0);
        chk({tag, ".starve_force"},  32'(starve_force),  32'd0);
        chk({tag, ".rd_ready"},      32'(rd_ready),      32'd0);
        chk({tag, ".wr_ready"},      32'(wr_ready),      32'd0);
    endtask

    // Sweep edges: edge k issues address k-1; readies held low; no read returns.
    task automatic sweep(input int n_edges);
        for (int k = 1; k <= n_edges; k++) begin
            rd_valid = 1'b1;
            wr_valid = 1'b0;
            #1;
            chk("sweep.rd_ready", 32'(rd_ready), 32'd0);
            chk("sweep.wr_ready", 32'(wr_ready), 32'd0);
            @(posedge clk); #1; cyc++;
            chk("sweep.mem_wren",      32'(mem_wren),      32'd1);
            chk("sweep.mem_address",   32'(mem_address),   32'(k - 1));
            chk("sweep.mem_data",      32'(mem_data),      32'(CLR));
            chk("sweep.init_done",     32'(init_done),     32'(k == DEP));
            chk("sweep.rd_data_valid", 32'(rd_data_valid), 32'd0);
        end
        rd_valid = 1'b0;
        exp_addr = AW'(n_edges - 1);
        exp_data = CLR;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_reset_vals(tag);
        exp_q.delete();
        wait_cycles = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One RUN cycle: reads win unless the pending write has waited LIMIT cycles.
    task automatic step(input logic rv, input logic [AW-1:0] ra, input logic wv,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        output logic wacc);
        logic    e_rr, e_wr, e_sf, racc, e_v;
        rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
        #1;
        e_rr = (wait_cycles != LIMIT);
        e_wr = (wait_cycles == LIMIT) || !rv;
        e_sf = (wait_cycles == LIMIT) && wv;
        chk("run.rd_ready",     32'(rd_ready),     32'(e_rr));
        chk("run.wr_ready",     32'(wr_ready),     32'(e_wr));
        chk("run.starve_force", 32'(starve_force), 32'(e_sf));
        racc = rv && e_rr;
        wacc = wv && e_wr && !racc;
        if (racc) exp_q.push_back('{due: cyc + 1 + LAT + 1, d: DW'(ra)});
        if (!wv || wacc) wait_cycles = 0;
        else if (wait_cycles < LIMIT) wait_cycles++;
        @(posedge clk); #1; cyc++;
        if (racc) exp_addr = ra;
        if (wacc) begin exp_addr = wa; exp_data = wd; end
        chk("run.mem_wren",    32'(mem_wren),    32'(wacc));
        chk("run.mem_address", 32'(mem_address), 32'(exp_addr));
        chk("run.mem_data",    32'(mem_data),    32'(exp_data));
        e_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("run.rd_data_valid", 32'(rd_data_valid), 32'(e_v));
        if (e_v) begin
            chk("run.rd_data", 32'(rd_data), 32'(exp_q[0].d));
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic          pend;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int            acc_at;

        #2 rst = 1'b1;
        #2 chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        sweep(DEP);

        // Consecutive reads 5,6,7 then idle to drain the returns.
        step(1'b1, 6'd5, 1'b0, '0, '0, acc);
        step(1'b1, 6'd6, 1'b0, '0, '0, acc);
        step(1'b1, 6'd7, 1'b0, '0, '0, acc);
        for (int i = 0; i < LAT + 3; i++) step(1'b0, '0, 1'b0, '0, '0, acc);

        // Write with the read side idle.
        step(1'b0, '0, 1'b1, 6'd3, 9'h0AA, acc);
        chk("idle_write.accept", 32'(acc), 32'd1);

        // Reads held continuously; the write must be force-granted on wait cycle LIMIT+1.
        acc_at = 0;
        for (int i = 1; i <= LIMIT + 4; i++) begin
            step(1'b1, 6'($urandom_range(0, 63)), acc_at == 0, 6'd10, 9'h155, acc);
            if (acc) acc_at = i;
        end
        chk("starve.accept_cycle", 32'(acc_at), 32'(LIMIT + 1));
        for (int i = 0; i < LAT + 3; i++) step(1'b0, '0, 1'b0, '0, '0, acc);

        // Random traffic; a write stays asserted with stable payload until accepted.
        pend = 1'b0; pa = '0; pd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                pa = 6'($urandom_range(0, 63));
                pd = 9'($urandom_range(0, 511));
            end
            step($urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)), pend, pa, pd, acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < LAT + 3; i++) step(1'b0, '0, 1'b0, '0, '0, acc);
        chk("random.drained", 32'(exp_q.size()), 32'd0);

        // Two reads in flight, then reset: no return pulse may follow.
        step(1'b1, 6'd20, 1'b0, '0, '0, acc);
        step(1'b1, 6'd21, 1'b0, '0, '0, acc);
        rd_valid = 1'b0;
        do_reset("rst_inflight");

        // Reset mid-sweep once address 7 is issued; the sweep restarts from 0.
        sweep(8);
        #2;
        do_reset("rst_midsweep");
        sweep(DEP);

        for (int i = 0; i < 4; i++) step(1'b1, 6'(40 + i), 1'b0, '0, '0, acc);
        for (int i = 0; i < LAT + 3; i++) step(1'b0, '0, 1'b0, '0, '0, acc);
        chk("final.drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
